// File: rtl/overflow_guard_accum.sv
// Burst accumulator: sums COUNT operand pairs per burst and presents one result with a sticky overflow flag.
// Optional build macro ACCUM_SATURATE_EN selects clamping instead of wrapping on overflow.
module overflow_guard_accum #(
    parameter int WIDTH = 4,
    parameter int COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic [WIDTH-1:0] i_in_a,
    input  logic [WIDTH-1:0] i_in_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_out_sum,
    output logic             o_out_ovf,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ACCUM = 2'b01,
        ST_DONE  = 2'b10
    } state_t;

    localparam logic [WIDTH+1:0] MAX_TOTAL = {2'b00, {WIDTH{1'b1}}};
    localparam logic [7:0]       LAST_IDX  = 8'(COUNT - 1);

    // Plain vector so the unused 2'b11 code point stays representable.
    logic [1:0]       r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_acc;
    logic             r_ovf;
    logic [7:0]       r_cnt;
    logic [WIDTH-1:0] r_out_sum;
    logic             r_out_ovf;

    logic [WIDTH:0]   w_pair;
    logic [WIDTH+1:0] w_total;
    logic             w_over;
    logic [WIDTH-1:0] w_acc_upd;
    logic             w_ovf_upd;
    logic             w_xfer;
    logic             w_last;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= 2'(ST_IDLE);
        end else begin
            r_state <= 2'(w_state_nxt);
        end
    end

    // Next-state and handshake decode from the registered state only.
    always_comb begin
        w_state_nxt = ST_IDLE;
        o_in_ready  = 1'b0;
        o_out_valid = 1'b0;
        o_busy      = 1'b1;
        case (r_state)
            2'(ST_IDLE): begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_state_nxt = ST_ACCUM;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            2'(ST_ACCUM): begin
                o_in_ready = 1'b1;
                if (w_last) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_ACCUM;
                end
            end
            2'(ST_DONE): begin
                o_out_valid = 1'b1;
                if (i_out_ready) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Overflow-checked sum of the incoming pair into the running total.
    always_comb begin
        w_pair    = {1'b0, i_in_a} + {1'b0, i_in_b};
        w_total   = {2'b00, r_acc} + {1'b0, w_pair};
        w_over    = (w_total > MAX_TOTAL);
        w_ovf_upd = r_ovf | w_over;
`ifdef ACCUM_SATURATE_EN
        if (w_over) begin
            w_acc_upd = {WIDTH{1'b1}};
        end else begin
            w_acc_upd = w_total[WIDTH-1:0];
        end
`else
        w_acc_upd = w_total[WIDTH-1:0];
`endif
        w_xfer = (r_state == 2'(ST_ACCUM)) && i_in_valid;
        w_last = w_xfer && (r_cnt == LAST_IDX);
    end

    // Accumulator, flag, pair counter and the registered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= 8'd0;
            r_out_sum <= '0;
            r_out_ovf <= 1'b0;
        end else begin
            case (r_state)
                2'(ST_IDLE): begin
                    if (i_start) begin
                        r_acc     <= '0;
                        r_ovf     <= 1'b0;
                        r_cnt     <= 8'd0;
                        r_out_sum <= '0;
                        r_out_ovf <= 1'b0;
                    end else begin
                        r_acc <= r_acc;
                    end
                end
                2'(ST_ACCUM): begin
                    if (w_xfer) begin
                        r_acc <= w_acc_upd;
                        r_ovf <= w_ovf_upd;
                        r_cnt <= r_cnt + 8'd1;
                        if (w_last) begin
                            r_out_sum <= w_acc_upd;
                            r_out_ovf <= w_ovf_upd;
                        end else begin
                            r_out_sum <= r_out_sum;
                        end
                    end else begin
                        r_acc <= r_acc;
                    end
                end
                2'(ST_DONE): begin
                    r_acc <= r_acc;
                end
                default: begin
                    // Corrupted state: drop everything rather than leak a partial result.
                    r_acc     <= '0;
                    r_ovf     <= 1'b0;
                    r_cnt     <= 8'd0;
                    r_out_sum <= '0;
                    r_out_ovf <= 1'b0;
                end
            endcase
        end
    end

    assign o_out_sum = r_out_sum;
    assign o_out_ovf = r_out_ovf;

endmodule
